word_packer: RTL

WORD_PACKER -- requirements
Module: word_packer

---
 rtl/word_packer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/word_packer.sv
// word_packer: pairs upstream bytes into 16-bit words, queues them
// in a small FIFO and issues them one per cycle with a ce strobe.
//
// Ports:
//   clk, rest_n          clock (rising edge), async active-low reset
//   byte_in/byte_valid   upstream byte and its valid
//   byte_ready           a byte is accepted when valid && ready
//   inv_sel              swap flag, taken with a word's second byte
//   flush                drops a held first byte, blocks acceptance
//   hold                 downstream stall, no word issued while high
//   data_out/inv/ce      issued word, its swap flag, new-word strobe
//   level                number of words waiting in the FIFO
module word_packer #(
  parameter int DEPTH   = 4,
  parameter bit BIG_END = 1'b0
) (
  input  logic                     clk,
  input  logic                     rest_n,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  input  logic                     inv_sel,
  input  logic                     flush,
  input  logic                     hold,
  output logic [15:0]              data_out,
  output logic                     ce,
  output logic                     inv,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {
    S_LOW,
    S_HIGH
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      first_q, first_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     dout_q, dout_d;
  logic            inv_q, inv_d;
  logic            ce_q, ce_d;

  // Entry layout: {inv, word}
  logic [16:0]     mem [DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic [15:0]     word;
  logic [16:0]     head;

  // A held first byte only needs FIFO room when its partner arrives.
  assign byte_ready = !flush &&
                      ((state_q == S_LOW) || (level_q < FULL));

  assign accept = byte_valid && byte_ready;
  assign push   = accept && (state_q == S_HIGH);
  assign pop    = (level_q != '0) && !hold;
  assign head   = mem[rd_ptr_q];

  always_comb begin
    word = {byte_in, first_q};
    if (BIG_END) begin
      word = {first_q, byte_in};
    end
  end

  // Pairing FSM; flush wins over any byte on the same edge.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    if (flush) begin
      state_d = S_LOW;
      first_d = 8'h00;
    end else if (accept) begin
      unique case (state_q)
        S_LOW: begin
          first_d = byte_in;
          state_d = S_HIGH;
        end
        S_HIGH: begin
          state_d = S_LOW;
        end
        default: begin
          state_d = S_LOW;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap since DEPTH is 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case (1'b1)
      (push && !pop): level_d = level_q + 1'b1;
      (pop && !push): level_d = level_q - 1'b1;
      default:        level_d = level_q;
    endcase
  end

  // Output stage keeps the last word until the next pop.
  always_comb begin
    dout_d = dout_q;
    inv_d  = inv_q;
    ce_d   = 1'b0;
    if (pop) begin
      dout_d = head[15:0];
      inv_d  = head[16];
      ce_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q  <= S_LOW;
      first_q  <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= 16'h0000;
      inv_q    <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      inv_q    <= inv_d;
      ce_q     <= ce_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {inv_sel, word};
    end
  end

  assign data_out = dout_q;
  assign inv      = inv_q;
  assign ce       = ce_q;
  assign level    = level_q;

endmodule
